// File: rtl/load_decoder_scoreboard.sv
// Destination-register scoreboard: tracks outstanding writes, gates issue on
// ownership, and turns legal writebacks into a one-hot register-file load.
module load_decoder_scoreboard #(
  parameter int ADDR_W       = 5,
  parameter int ZERO_PROTECT = 1,
  localparam int NUM_REGS    = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_dest,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_dest,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   src_a,
  input  logic [ADDR_W-1:0]   src_b,
  output logic                hazard,
  output logic [NUM_REGS-1:0] load,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     pending,
  output logic                wb_err
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] load_q, load_d;
  logic [ADDR_W:0]     pending_q, pending_d;
  logic                wb_err_q, wb_err_d;

  logic iss_zp, wb_zp, issue_acc, wb_legal;

  assign iss_zp      = (ZERO_PROTECT != 0) && (issue_dest == '0);
  assign wb_zp       = (ZERO_PROTECT != 0) && (wb_dest == '0);
  assign issue_ready = iss_zp | ~busy_q[issue_dest];
  assign issue_acc   = issue_valid & issue_ready;
  // busy_q[0] is never set under protection, so a protected wb to r0 is never legal
  assign wb_legal    = wb_valid & busy_q[wb_dest];
  assign hazard      = busy_q[src_a] | busy_q[src_b];

  always_comb begin
    busy_d    = busy_q;
    load_d    = '0;
    wb_err_d  = 1'b0;
    pending_d = '0;
    if (wb_legal) begin
      busy_d[wb_dest] = 1'b0;
      load_d[wb_dest] = 1'b1;
    end else if (wb_valid && !wb_zp) begin
      wb_err_d = 1'b1;
    end
    // a legal wb and an accepted issue can never target the same register
    if (issue_acc && !iss_zp) busy_d[issue_dest] = 1'b1;
    if (flush) begin
      busy_d   = '0;
      load_d   = '0;
      wb_err_d = 1'b0;
    end
    for (int i = 0; i < NUM_REGS; i++) pending_d = pending_d + (ADDR_W+1)'(busy_d[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      load_q    <= '0;
      pending_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      load_q    <= load_d;
      pending_q <= pending_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign busy    = busy_q;
  assign load    = load_q;
  assign pending = pending_q;
  assign wb_err  = wb_err_q;

endmodule

// File: tb/tb_load_decoder_scoreboard.sv
// Directed scoreboard bench: one stimulus stream drives a protected (ZP=1) and
// an unprotected (ZP=0) instance; a monitor checks queued expectations per cycle.
module tb_load_decoder_scoreboard;

  localparam int AW = 5;

  logic clk = 1'b0, rst_n = 1'b1;
  logic iv = 1'b0, wv = 1'b0, fl = 1'b0;
  logic [AW-1:0] id = '0, wd = '0, sa = '0, sb = '0;

  logic          rdy_z, haz_z, err_z, rdy_n, haz_n, err_n;
  logic [31:0]   busy_z, load_z, busy_n, load_n;
  logic [AW:0]   pend_z, pend_n;

  load_decoder_scoreboard #(.ADDR_W(AW), .ZERO_PROTECT(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .issue_valid(iv), .issue_dest(id), .issue_ready(rdy_z),
    .wb_valid(wv), .wb_dest(wd), .flush(fl), .src_a(sa), .src_b(sb), .hazard(haz_z),
    .load(load_z), .busy(busy_z), .pending(pend_z), .wb_err(err_z));

  load_decoder_scoreboard #(.ADDR_W(AW), .ZERO_PROTECT(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .issue_valid(iv), .issue_dest(id), .issue_ready(rdy_n),
    .wb_valid(wv), .wb_dest(wd), .flush(fl), .src_a(sa), .src_b(sb), .hazard(haz_n),
    .load(load_n), .busy(busy_n), .pending(pend_n), .wb_err(err_n));

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          is_reg;
    logic        rdy, haz, err, n_rdy, n_haz, n_err;
    logic [31:0] busy, load, n_busy, n_load;
    logic [5:0]  pend, n_pend;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   ncmp = 0, nerr = 0;

  // expectations for the unprotected instance when they differ from ZP=1
  bit          use_n = 0;
  logic        o_rdy, o_haz, o_err;
  logic [31:0] o_busy, o_load;
  logic [5:0]  o_pend;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, a, e);
    end
  endtask

  task automatic nset(input logic r, h, input logic [31:0] b, l, input logic [5:0] p, input logic e);
    use_n = 1; o_rdy = r; o_haz = h; o_busy = b; o_load = l; o_pend = p; o_err = e;
  endtask

  // one clock of stimulus; e_* are the ZP=1 expectations
  task automatic step(input logic i_v, input logic [4:0] i_d, input logic w_v, input logic [4:0] w_d,
                      input logic f, input logic [4:0] s_a, s_b,
                      input logic e_rdy, e_haz, input logic [31:0] e_busy, e_load,
                      input logic [5:0] e_pend, input logic e_err);
    exp_t c, r;
    @(posedge clk); #1;
    iv = i_v; id = i_d; wv = w_v; wd = w_d; fl = f; sa = s_a; sb = s_b;
    c = '{due: cyc, is_reg: 0, rdy: e_rdy, haz: e_haz, err: 0, n_rdy: e_rdy, n_haz: e_haz,
          n_err: 0, busy: 0, load: 0, n_busy: 0, n_load: 0, pend: 0, n_pend: 0};
    r = '{due: cyc + 1, is_reg: 1, rdy: 0, haz: 0, err: e_err, n_rdy: 0, n_haz: 0, n_err: e_err,
          busy: e_busy, load: e_load, n_busy: e_busy, n_load: e_load, pend: e_pend, n_pend: e_pend};
    if (use_n) begin
      c.n_rdy = o_rdy; c.n_haz = o_haz;
      r.n_busy = o_busy; r.n_load = o_load; r.n_pend = o_pend; r.n_err = o_err;
      use_n = 0;
    end
    q.push_back(c);
    q.push_back(r);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy_z"}, 64'(busy_z), 0); chk({tag, " load_z"}, 64'(load_z), 0);
    chk({tag, " pend_z"}, 64'(pend_z), 0); chk({tag, " err_z"}, 64'(err_z), 0);
    chk({tag, " busy_n"}, 64'(busy_n), 0); chk({tag, " load_n"}, 64'(load_n), 0);
    chk({tag, " pend_n"}, 64'(pend_n), 0); chk({tag, " err_n"}, 64'(err_n), 0);
  endtask

  // monitor: checks every expectation that falls due in the current cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      if (!e.is_reg) begin
        chk("issue_ready_z", 64'(rdy_z), 64'(e.rdy));   chk("hazard_z", 64'(haz_z), 64'(e.haz));
        chk("issue_ready_n", 64'(rdy_n), 64'(e.n_rdy)); chk("hazard_n", 64'(haz_n), 64'(e.n_haz));
      end else begin
        chk("busy_z", 64'(busy_z), 64'(e.busy));   chk("load_z", 64'(load_z), 64'(e.load));
        chk("pending_z", 64'(pend_z), 64'(e.pend)); chk("wb_err_z", 64'(err_z), 64'(e.err));
        chk("busy_n", 64'(busy_n), 64'(e.n_busy)); chk("load_n", 64'(load_n), 64'(e.n_load));
        chk("pending_n", 64'(pend_n), 64'(e.n_pend)); chk("wb_err_n", 64'(err_n), 64'(e.n_err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d expectations left", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2 chk_zero("por");
    #9 rst_n = 1'b1;
    //    iv id  wv wd  fl sa sb   rdy haz busy        load        pend err
    step(0, 0,  0, 0,  0, 0, 0,   1,  0,  32'h0,      32'h0,      0,   0);
    // issue 7, wb 7 two cycles later
    step(1, 7,  0, 0,  0, 7, 0,   1,  0,  32'h80,     32'h0,      1,   0);
    step(0, 0,  0, 0,  0, 0, 7,   1,  1,  32'h80,     32'h0,      1,   0);
    step(0, 0,  1, 7,  0, 7, 0,   1,  1,  32'h0,      32'h80,     0,   0);
    step(0, 0,  0, 0,  0, 7, 0,   1,  0,  32'h0,      32'h0,      0,   0);
    // re-issue to a busy register stalls until its writeback
    step(1, 3,  0, 0,  0, 0, 0,   1,  0,  32'h8,      32'h0,      1,   0);
    step(1, 3,  0, 0,  0, 0, 0,   0,  0,  32'h8,      32'h0,      1,   0);
    step(1, 3,  1, 3,  0, 0, 0,   0,  0,  32'h0,      32'h8,      0,   0);
    step(1, 3,  0, 0,  0, 0, 0,   1,  0,  32'h8,      32'h0,      1,   0);
    step(0, 0,  1, 3,  0, 0, 0,   1,  0,  32'h0,      32'h8,      0,   0);
    // stray writeback
    step(0, 0,  1, 9,  0, 0, 0,   1,  0,  32'h0,      32'h0,      0,   1);
    step(0, 0,  0, 0,  0, 0, 0,   1,  0,  32'h0,      32'h0,      0,   0);
    // issue and writeback to different registers on the same edge
    step(1, 4,  0, 0,  0, 0, 0,   1,  0,  32'h10,     32'h0,      1,   0);
    step(1, 5,  1, 4,  0, 0, 0,   1,  0,  32'h20,     32'h10,     1,   0);
    step(0, 0,  1, 5,  0, 0, 0,   1,  0,  32'h0,      32'h20,     0,   0);
    // register 0: protected vs ordinary
    nset(1, 0, 32'h1, 32'h0, 1, 0);
    step(1, 0,  0, 0,  0, 0, 0,   1,  0,  32'h0,      32'h0,      0,   0);
    nset(0, 1, 32'h1, 32'h0, 1, 0);
    step(0, 0,  0, 0,  0, 0, 0,   1,  0,  32'h0,      32'h0,      0,   0);
    nset(0, 1, 32'h0, 32'h1, 0, 0);
    step(0, 0,  1, 0,  0, 0, 0,   1,  0,  32'h0,      32'h0,      0,   0);
    nset(1, 0, 32'h0, 32'h0, 0, 1);
    step(0, 0,  1, 0,  0, 0, 0,   1,  0,  32'h0,      32'h0,      0,   0);
    step(0, 0,  0, 0,  0, 0, 0,   1,  0,  32'h0,      32'h0,      0,   0);
    // flush beats a same-cycle writeback and issue
    step(1, 1,  0, 0,  0, 0, 0,   1,  0,  32'h2,      32'h0,      1,   0);
    step(1, 2,  0, 0,  0, 0, 0,   1,  0,  32'h6,      32'h0,      2,   0);
    step(1, 31, 0, 0,  0, 0, 0,   1,  0,  32'h80000006, 32'h0,    3,   0);
    step(1, 9,  1, 2,  1, 2, 0,   1,  1,  32'h0,      32'h0,      0,   0);
    step(0, 0,  0, 0,  0, 2, 31,  1,  0,  32'h0,      32'h0,      0,   0);
    // asynchronous reset mid-operation
    step(1, 5,  0, 0,  0, 0, 0,   1,  0,  32'h20,     32'h0,      1,   0);
    step(1, 6,  0, 0,  0, 0, 0,   1,  0,  32'h60,     32'h0,      2,   0);
    @(posedge clk); #1;
    iv = 0; wv = 0; fl = 0; sa = 5; sb = 6;
    @(negedge clk); #2;
    chk("pre-reset busy_z", 64'(busy_z), 64'h60);
    rst_n = 1'b0; wv = 1; wd = 5;
    #1 chk_zero("async-reset");
    chk("async-reset hazard_z", 64'(haz_z), 0);
    chk("async-reset hazard_n", 64'(haz_n), 0);
    @(posedge clk); #1 chk_zero("in-reset");
    @(negedge clk); #1 rst_n = 1'b1;
    step(0, 0,  1, 5,  0, 5, 0,   1,  0,  32'h0,      32'h0,      0,   1);
    step(1, 6,  0, 0,  0, 0, 0,   1,  0,  32'h40,     32'h0,      1,   0);
    step(0, 0,  0, 0,  0, 6, 0,   1,  1,  32'h40,     32'h0,      1,   0);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d expectations never checked", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
